// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: S = A - B, one decimal digit per clock, LSD first.
// Final borrow on C, invalid-digit flag on err; results held until the next operation.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | one digit processed per cycle, DIGITS cycles in total
// FIN   | results copied to S/C/err; done pulses on the following cycle
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    output logic [4*DIGITS-1:0] S,
    output logic                C,
    output logic                err,
    output logic                busy,
    output logic                done
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, b_sh, acc;
    logic [CW-1:0]  cnt;
    logic           br, err_acc;
    logic           last;
    logic [4:0]     t, t_adj;
    logic [3:0]     d;
    logic           br_nx, bad;
    logic [W-1:0]   acc_nx;

    assign last = (cnt == CW'(DIGITS - 1));

    // One digit of the subtraction on the current low nibbles
    always_comb begin
        t      = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, br};
        t_adj  = t + 5'd10;
        br_nx  = t[4];
        d      = br_nx ? t_adj[3:0] : t[3:0];
        bad    = (a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9);
        acc_nx = (acc >> 4) | (W'(d) << (W - 4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            err_acc <= 1'b0;
            S       <= '0;
            C       <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // busy/done trail the state by one cycle so they line up with the result update
            busy <= (state == RUN);
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        br      <= 1'b0;
                        cnt     <= '0;
                        err_acc <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    acc     <= acc_nx;
                    br      <= br_nx;
                    err_acc <= err_acc | bad;
                    cnt     <= cnt + CW'(1);
                end
                FIN: begin
                    S   <= err_acc ? '0 : acc;
                    C   <= br & ~err_acc;
                    err <= err_acc;
                end
                default: ;
            endcase
        end
    end

endmodule
